// File: rtl/reload_timer_pkg.sv
// Shared definitions for the reload timer: terminal-count modes, the
// per-cycle action priority, and a helper that folds the reserved mode code.
package reload_timer_pkg;

    // Terminal-count behaviour selected by modeIn.
    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // What the counter does in a given cycle, listed from highest to lowest
    // priority: reset beats load, load beats a prescaler tick, and with none
    // of those the counter holds.
    typedef enum logic [1:0] {
        ACT_RESET = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_TICK  = 2'd2,
        ACT_HOLD  = 2'd3
    } action_e;

    localparam int PRIO_RESET = 0;
    localparam int PRIO_LOAD  = 1;
    localparam int PRIO_TICK  = 2;
    localparam int PRIO_HOLD  = 3;

    // The reserved encoding behaves exactly like free-running mode.
    function automatic mode_e decodeMode(input logic [1:0] modeRaw);
        mode_e m;
        m = mode_e'(modeRaw);
        if (m == MODE_RSVD) begin
            m = MODE_FREE;
        end
        return m;
    endfunction

endpackage

// File: rtl/reload_timer_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every prescaleIn+1 enabled
// cycles. Disabling freezes the count; clearing restarts it from zero.
module timer_prescaler
    import reload_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] count_q;
    logic [PRESCALE_WIDTH-1:0] count_d;

    // The tick is combinational so the counter core can act on it in the
    // same cycle; the comparison always uses the live prescale value, and an
    // overshoot after lowering it simply wraps around through zero.
    always_comb begin
        tick_o  = enable_i && (count_q == prescale_i);
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (tick_o) begin
                count_d = '0;
            end else begin
                count_d = count_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    // Prescaler count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reload_timer.sv
// General-purpose up/down counter/timer with programmable prescaler,
// free-run / auto-reload / one-shot terminal handling and a compare-match
// pulse. All outputs are registered.
module reload_timer
    import reload_timer_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] INIT           = '0,
    parameter int               PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      countEn,
    input  logic                      loadEn,
    input  logic                      downMode,
    input  logic [1:0]                modeIn,
    input  logic [PRESCALE_WIDTH-1:0] prescaleIn,
    input  logic [WIDTH-1:0]          valueIn,
    input  logic [WIDTH-1:0]          reloadIn,
    input  logic [WIDTH-1:0]          compareIn,
    output logic [WIDTH-1:0]          valueOut,
    output logic                      carryOut,
    output logic                      matchOut,
    output logic                      runningOut
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             carry_q;
    logic             carry_d;
    logic             match_q;
    logic             match_d;
    logic             running_q;
    logic             running_d;

    logic             tick;
    logic             isTerminal;
    logic [WIDTH-1:0] stepped;
    mode_e            effMode;
    action_e          action;

    // A load restarts the prescaler; a stopped one-shot freezes it entirely.
    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) uPrescaler (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (loadEn),
        .enable_i  (countEn && running_q),
        .prescale_i(prescaleIn),
        .tick_o    (tick)
    );

    // Decode the action for this cycle in priority order; reset is applied
    // directly in the register block below.
    always_comb begin
        if (loadEn) begin
            action = ACT_LOAD;
        end else if (tick) begin
            action = ACT_TICK;
        end else begin
            action = ACT_HOLD;
        end
    end

    // Direction, terminal detection and mode are all sampled from the live
    // inputs at tick time, so mid-count changes only matter at the next tick.
    always_comb begin
        effMode    = decodeMode(modeIn);
        isTerminal = downMode ? (value_q == '0) : (value_q == '1);
        stepped    = downMode ? (value_q - WIDTH'(1)) : (value_q + WIDTH'(1));
    end

    // Next-state logic: loads never pulse; a tick steps or applies the
    // terminal rule, and the match pulse looks at the value the tick produces.
    always_comb begin
        value_d   = value_q;
        carry_d   = 1'b0;
        match_d   = 1'b0;
        running_d = running_q;
        case (action)
            ACT_LOAD: begin
                value_d   = valueIn;
                running_d = 1'b1;
            end
            ACT_TICK: begin
                if (isTerminal) begin
                    carry_d = 1'b1;
                    case (effMode)
                        MODE_RELOAD: begin
                            value_d = reloadIn;
                        end
                        MODE_ONESHOT: begin
                            value_d   = value_q;
                            running_d = 1'b0;
                        end
                        default: begin
                            value_d = stepped;
                        end
                    endcase
                end else begin
                    value_d = stepped;
                end
                match_d = (value_d == compareIn);
            end
            default: begin
                value_d = value_q;
            end
        endcase
    end

    // Output registers; reset outranks every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= INIT;
            carry_q   <= 1'b0;
            match_q   <= 1'b0;
            running_q <= 1'b1;
        end else begin
            value_q   <= value_d;
            carry_q   <= carry_d;
            match_q   <= match_d;
            running_q <= running_d;
        end
    end

    assign valueOut   = value_q;
    assign carryOut   = carry_q;
    assign matchOut   = match_q;
    assign runningOut = running_q;

endmodule

// File: tb/tb_reload_timer.sv
// Testbench for reload_timer: directed scenarios with literal expectations
// plus a randomized run compared against a behavioural model.
module tb_reload_timer;

    localparam int WIDTH = 8;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             countEn;
    logic             loadEn;
    logic             downMode;
    logic [1:0]       modeIn;
    logic [PW-1:0]    prescaleIn;
    logic [WIDTH-1:0] valueIn;
    logic [WIDTH-1:0] reloadIn;
    logic [WIDTH-1:0] compareIn;
    logic [WIDTH-1:0] valueOut;
    logic             carryOut;
    logic             matchOut;
    logic             runningOut;
    logic [WIDTH-1:0] valueOut2;
    logic             carryOut2;
    logic             matchOut2;
    logic             runningOut2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int mVal;
    int mPre;
    bit mRun;
    bit mCarry;
    bit mMatch;

    reload_timer #(.WIDTH(WIDTH), .INIT(8'h00), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .countEn(countEn), .loadEn(loadEn),
        .downMode(downMode), .modeIn(modeIn), .prescaleIn(prescaleIn),
        .valueIn(valueIn), .reloadIn(reloadIn), .compareIn(compareIn),
        .valueOut(valueOut), .carryOut(carryOut), .matchOut(matchOut),
        .runningOut(runningOut)
    );

    reload_timer #(.WIDTH(WIDTH), .INIT(8'hA5), .PRESCALE_WIDTH(PW)) dut2 (
        .clk(clk), .reset(reset), .countEn(countEn), .loadEn(loadEn),
        .downMode(downMode), .modeIn(modeIn), .prescaleIn(prescaleIn),
        .valueIn(valueIn), .reloadIn(reloadIn), .compareIn(compareIn),
        .valueOut(valueOut2), .carryOut(carryOut2), .matchOut(matchOut2),
        .runningOut(runningOut2)
    );

    always #5 clk = ~clk;

    // One clock of the timer described arithmetically from its rules.
    task automatic modelStep();
        bit tickNow;
        tickNow = 1'b0;
        mCarry  = 1'b0;
        mMatch  = 1'b0;
        if (reset) begin
            mVal = 0;
            mPre = 0;
            mRun = 1'b1;
        end else if (loadEn) begin
            mVal = int'(valueIn);
            mPre = 0;
            mRun = 1'b1;
        end else begin
            if (countEn && mRun) begin
                if (mPre == int'(prescaleIn)) begin
                    tickNow = 1'b1;
                    mPre    = 0;
                end else begin
                    mPre = (mPre + 1) % 16;
                end
            end
            if (tickNow) begin
                if ((!downMode && mVal == 255) || (downMode && mVal == 0)) begin
                    mCarry = 1'b1;
                    if (modeIn == 2'd1) mVal = int'(reloadIn);
                    else if (modeIn == 2'd2) mRun = 1'b0;
                    else mVal = downMode ? 255 : 0;
                end else begin
                    mVal = downMode ? mVal - 1 : mVal + 1;
                end
                mMatch = (mVal == int'(compareIn));
            end
        end
    endtask

    // Advance one clock, keeping the model in step; outputs sampled #1 later.
    task automatic advance();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; loadEn = 1'b1; countEn = 1'b1; valueIn = 8'h55;
        downMode = 1'b0; modeIn = 2'd0; prescaleIn = '0;
        reloadIn = 8'h00; compareIn = 8'h00;
        advance();
        advance();
        checks++;
        if (valueOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_value: got %h expected 00", valueOut); end
        checks++;
        if (carryOut !== 1'b0 || matchOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got carry=%b match=%b expected 0 0", carryOut, matchOut); end
        checks++;
        if (runningOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_running: got %b expected 1", runningOut); end
        checks++;
        if (valueOut2 !== 8'hA5) begin errors++; $display("[TB] FAIL reset_init_a5: got %h expected a5", valueOut2); end
        reset = 1'b0; loadEn = 1'b0; countEn = 1'b0;
    endtask

    task automatic test_free_up();
        logic [7:0] expV [3];
        logic       expC [3];
        logic       expM [3];
        expV = '{8'hFF, 8'h00, 8'h01};
        expC = '{1'b0, 1'b1, 1'b0};
        expM = '{1'b0, 1'b0, 1'b1};
        modeIn = 2'd0; downMode = 1'b0; prescaleIn = 4'd0; compareIn = 8'h01;
        loadEn = 1'b1; valueIn = 8'hFE;
        advance();
        loadEn = 1'b0;
        checks++;
        if (valueOut !== 8'hFE || carryOut !== 1'b0) begin errors++; $display("[TB] FAIL free_load: got %h/%b expected fe/0", valueOut, carryOut); end
        countEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (valueOut !== expV[i] || carryOut !== expC[i] || matchOut !== expM[i]) begin
                errors++;
                $display("[TB] FAIL free_up step %0d: got v=%h c=%b m=%b expected v=%h c=%b m=%b",
                         i, valueOut, carryOut, matchOut, expV[i], expC[i], expM[i]);
            end
        end
        countEn = 1'b0;
    endtask

    task automatic test_prescaler();
        compareIn = 8'hEE; modeIn = 2'd0; downMode = 1'b0; prescaleIn = 4'd3;
        loadEn = 1'b1; valueIn = 8'h10;
        advance();
        loadEn = 1'b0; countEn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            advance();
            checks++;
            if (valueOut !== ((i >= 4) ? 8'h11 : 8'h10)) begin
                errors++; $display("[TB] FAIL prescale_run cycle %0d: got %h", i, valueOut);
            end
        end
        countEn = 1'b0;
        repeat (5) advance();
        checks++;
        if (valueOut !== 8'h11) begin errors++; $display("[TB] FAIL prescale_pause: got %h expected 11", valueOut); end
        countEn = 1'b1;
        advance();
        checks++;
        if (valueOut !== 8'h11) begin errors++; $display("[TB] FAIL prescale_resume1: got %h expected 11", valueOut); end
        advance();
        checks++;
        if (valueOut !== 8'h12) begin errors++; $display("[TB] FAIL prescale_resume2: got %h expected 12", valueOut); end
        countEn = 1'b0;
    endtask

    task automatic test_reload_down();
        logic [7:0] expV [5];
        logic       expC [5];
        expV = '{8'h02, 8'h01, 8'h00, 8'h05, 8'h04};
        expC = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        modeIn = 2'd1; downMode = 1'b1; prescaleIn = 4'd0; reloadIn = 8'h05; compareIn = 8'hEE;
        loadEn = 1'b1; valueIn = 8'h03;
        advance();
        loadEn = 1'b0; countEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            advance();
            checks++;
            if (valueOut !== expV[i] || carryOut !== expC[i]) begin
                errors++;
                $display("[TB] FAIL reload_down step %0d: got v=%h c=%b expected v=%h c=%b",
                         i, valueOut, carryOut, expV[i], expC[i]);
            end
        end
        countEn = 1'b0;
    endtask

    task automatic test_oneshot();
        modeIn = 2'd2; downMode = 1'b0; prescaleIn = 4'd0; compareIn = 8'hFF;
        loadEn = 1'b1; valueIn = 8'hFD;
        advance();
        loadEn = 1'b0; countEn = 1'b1;
        advance();
        advance();
        checks++;
        if (valueOut !== 8'hFF || carryOut !== 1'b0 || matchOut !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_reach: got v=%h c=%b m=%b expected ff 0 1", valueOut, carryOut, matchOut); end
        advance();
        checks++;
        if (valueOut !== 8'hFF || carryOut !== 1'b1 || matchOut !== 1'b1 || runningOut !== 1'b0) begin
            errors++; $display("[TB] FAIL oneshot_term: got v=%h c=%b m=%b r=%b expected ff 1 1 0", valueOut, carryOut, matchOut, runningOut);
        end
        repeat (10) advance();
        checks++;
        if (valueOut !== 8'hFF || carryOut !== 1'b0 || matchOut !== 1'b0 || runningOut !== 1'b0) begin
            errors++; $display("[TB] FAIL oneshot_stopped: got v=%h c=%b m=%b r=%b expected ff 0 0 0", valueOut, carryOut, matchOut, runningOut);
        end
        countEn = 1'b0; loadEn = 1'b1; valueIn = 8'h10;
        advance();
        loadEn = 1'b0;
        checks++;
        if (valueOut !== 8'h10 || runningOut !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_rearm: got v=%h r=%b expected 10 1", valueOut, runningOut); end
        countEn = 1'b1;
        advance();
        checks++;
        if (valueOut !== 8'h11) begin errors++; $display("[TB] FAIL oneshot_resume: got %h expected 11", valueOut); end
        countEn = 1'b0;
    endtask

    task automatic test_load_priority();
        modeIn = 2'd0; downMode = 1'b0; prescaleIn = 4'd1; compareIn = 8'hEE;
        loadEn = 1'b1; valueIn = 8'hFF;
        advance();
        loadEn = 1'b0; countEn = 1'b1;
        advance();
        loadEn = 1'b1; valueIn = 8'h42;
        advance();
        loadEn = 1'b0;
        checks++;
        if (valueOut !== 8'h42 || carryOut !== 1'b0) begin errors++; $display("[TB] FAIL load_over_tick: got v=%h c=%b expected 42 0", valueOut, carryOut); end
        advance();
        checks++;
        if (valueOut !== 8'h42) begin errors++; $display("[TB] FAIL load_clears_prescaler: got %h expected 42", valueOut); end
        advance();
        checks++;
        if (valueOut !== 8'h43) begin errors++; $display("[TB] FAIL load_then_count: got %h expected 43", valueOut); end
        countEn = 1'b0;
    endtask

    task automatic test_mid_reset();
        modeIn = 2'd2; downMode = 1'b0; prescaleIn = 4'd0;
        loadEn = 1'b1; valueIn = 8'hFF;
        advance();
        loadEn = 1'b0; countEn = 1'b1;
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0; countEn = 1'b0;
        checks++;
        if (valueOut !== 8'h00 || runningOut !== 1'b1 || carryOut !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset: got v=%h r=%b c=%b expected 00 1 0", valueOut, runningOut, carryOut);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(99) < 2);
            loadEn     = ($urandom_range(99) < 6);
            countEn    = ($urandom_range(99) < 80);
            downMode   = ($urandom_range(99) < 10) ? ~downMode : downMode;
            modeIn     = ($urandom_range(99) < 5) ? 2'($urandom_range(3)) : modeIn;
            prescaleIn = ($urandom_range(99) < 5) ? 4'($urandom_range(3)) : prescaleIn;
            valueIn    = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'($urandom_range(255, 250));
            reloadIn   = 8'($urandom_range(255));
            compareIn  = 8'($urandom_range(3));
            advance();
            checks++;
            if (int'(valueOut) != mVal || carryOut !== mCarry || matchOut !== mMatch || runningOut !== mRun) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got v=%h c=%b m=%b r=%b expected v=%h c=%b m=%b r=%b",
                         i, valueOut, carryOut, matchOut, runningOut, 8'(mVal), mCarry, mMatch, mRun);
            end
        end
        reset = 1'b0; loadEn = 1'b0; countEn = 1'b0;
    endtask

    initial begin
        mVal = 0; mPre = 0; mRun = 1'b1; mCarry = 1'b0; mMatch = 1'b0;
        test_reset();
        test_free_up();
        test_prescaler();
        test_reload_down();
        test_oneshot();
        test_load_priority();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
